// File: rtl/leaf_link_host.sv
// Host end of the leaf link: opens a session, collects the leaf's dual-rail message, then sends the payload bit-serially.
// Optional wait-state watchdog is enabled with `define LEAF_HOST_TIMEOUT_EN.

module leaf_link_pair_dec (
    input  logic [1:0] rail,
    output logic       vld,
    output logic       ill,
    output logic       val
);
    assign vld = rail[0] ^ rail[1];
    assign ill = &rail;
    assign val = rail[0];
endmodule

module leaf_link_host #(
    parameter int NOC_WID     = 16,
    parameter int SEND_LEN    = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SEND_LEN-1:0]   payload,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [NOC_WID-1:0]    rx_msg,
    output logic                  rx_msg_vld,
    output logic                  link_pr,
    output logic [1:0]            link_pd,
    input  logic                  link_pa,
    input  logic [2*NOC_WID-1:0]  link_rd,
    output logic                  link_ra
);
    localparam int IDX_W = (SEND_LEN > 1) ? $clog2(SEND_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEND_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_MSG, S_MACK, S_DATA, S_NULL, S_REL
    } state_t;

    state_t state, next_state;
    logic [SEND_LEN-1:0] pay_q;
    logic [IDX_W-1:0]    idx;

    logic [NOC_WID-1:0] pair_vld, pair_ill, pair_val;
    logic all_vld, any_ill, rd_null;
    logic accept, cap, set_err, fin, idx_inc, tmo;

    for (genvar i = 0; i < NOC_WID; i++) begin : g_pair
        leaf_link_pair_dec u_dec (
            .rail (link_rd[2*i+1:2*i]),
            .vld  (pair_vld[i]),
            .ill  (pair_ill[i]),
            .val  (pair_val[i])
        );
    end

    assign all_vld = &pair_vld;
    assign any_ill = |pair_ill;
    assign rd_null = (link_rd == '0);

`ifdef LEAF_HOST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;

    assign tmo = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (next_state != state)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign tmo = 1'b0;
`endif

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        cap        = 1'b0;
        set_err    = 1'b0;
        fin        = 1'b0;
        idx_inc    = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                accept     = 1'b1;
                next_state = S_REQ;
            end
            S_REQ:  if (link_pa) next_state = S_MSG;
            S_MSG: begin
                if (any_ill) begin
                    set_err    = 1'b1;
                    next_state = S_REL;
                end else if (all_vld) begin
                    cap        = 1'b1;
                    next_state = S_MACK;
                end
            end
            S_MACK: if (rd_null) next_state = S_DATA;
            S_DATA: if (!link_pa) next_state = S_NULL;
            S_NULL: if (link_pa) begin
                if (idx == LAST_IDX) begin
                    next_state = S_REL;
                end else begin
                    idx_inc    = 1'b1;
                    next_state = S_DATA;
                end
            end
            S_REL: if (!link_pa) begin
                fin        = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        // Watchdog only fires when the state would otherwise have stayed put.
        if (tmo && state != S_IDLE && next_state == state) begin
            if (state == S_REL) begin
                fin        = 1'b1;
                next_state = S_IDLE;
            end else begin
                set_err    = 1'b1;
                next_state = S_REL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pay_q      <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rx_msg     <= '0;
            rx_msg_vld <= 1'b0;
            link_pr    <= 1'b0;
            link_pd    <= 2'b00;
            link_ra    <= 1'b0;
        end else begin
            state      <= next_state;
            busy       <= (next_state != S_IDLE);
            done       <= fin;
            rx_msg_vld <= cap;
            if (cap)
                rx_msg <= pair_val;
            if (accept) begin
                pay_q <= payload;
                idx   <= '0;
                err   <= 1'b0;
            end else begin
                if (set_err)
                    err <= 1'b1;
                if (idx_inc)
                    idx <= idx + 1'b1;
            end
            // Link outputs are a registered decode of the current state.
            link_pr <= (state == S_REQ) || (state == S_MSG) || (state == S_MACK) ||
                       (state == S_DATA) || (state == S_NULL);
            link_ra <= (state == S_MACK);
            link_pd <= (state == S_DATA) ? (pay_q[idx] ? 2'b01 : 2'b10) : 2'b00;
        end
    end
endmodule

// File: doc/leaf_link_host.md
# leaf_link_host

Host-side end of the leaf link. It opens a session toward a leaf with a request line and collects the leaf's dual-rail NOC_WID-bit message, acknowledging it on a return ack. It then shifts a SEND_LEN-bit payload to the leaf one dual-rail bit at a time using four-phase handshakes, and finally closes the session. It sits in the NoC fabric between a local controller and one leaf, in the same clock domain as the leaf.

## Interface
- NOC_WID, 16, message width in bits; the leaf drives 2*NOC_WID rails.
- SEND_LEN, 8, payload bits sent per session; minimum 1.
- TIMEOUT_CYC, 1024, wait-state limit in cycles; used only with LEAF_HOST_TIMEOUT_EN.

- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to open a session; sampled only in IDLE.
- payload  in  SEND_LEN  bits to send, latched on accepted start, sent LSB first.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a session closes, with or without error.
- err  out  1  sticky error flag; cleared on the next accepted start.
- rx_msg  out  NOC_WID  decoded leaf message; holds its value until the next capture.
- rx_msg_vld  out  1  one-cycle pulse when rx_msg is updated.
- link_pr  out  1  session request to the leaf.
- link_pd  out  2  dual-rail data bit; bit0 = one-rail, bit1 = zero-rail.
- link_pa  in  1  leaf ack.
- link_rd  in  2*NOC_WID  leaf message rails; pair i = link_rd[2i+1:2i].
- link_ra  out  1  message ack to the leaf.

## Operation
- Dual-rail codes, both directions:
  - 01 = logic 1.
  - 10 = logic 0.
  - 00 = null.
  - 11 = illegal.
- Message states:
  - The message is complete when every pair is 01 or 10.
  - The message is null when link_rd == 0.
- FSM, Moore; all outputs are registered and decoded from state:
  - IDLE: pr=0, pd=00, ra=0. On start, latch payload, clear err, set bit index to 0, go to REQ.
  - REQ: pr=1. When pa=1, go to MSG.
  - MSG: pr=1. On any illegal pair, set err and go to REL. When the message is complete, capture rx_msg, pulse rx_msg_vld, and go to MACK.
  - MACK: pr=1, ra=1. When the message is null, go to DATA.
  - DATA: pr=1, pd = code of payload[idx]. When pa=0, go to NULL.
  - NULL: pr=1, pd=00. When pa=1: if idx == SEND_LEN-1, go to REL; otherwise increment idx and go to DATA.
  - REL: pr=0, pd=00, ra=0. When pa=0, pulse done and go to IDLE.
- Illegal-pair detection runs only in MSG; link_rd is ignored in all other states.
- start while busy is ignored; it is not queued.
- The bit index is a $clog2(SEND_LEN)-bit counter (minimum 1 bit) and never wraps within a session.

## Timing
- Reset values: link_pr=0, link_pd=00, link_ra=0, busy=0, done=0, err=0, rx_msg=0, rx_msg_vld=0; state is IDLE.
- Asserting rst_n low mid-session forces all outputs to their reset values immediately, without waiting for a clock edge. No done pulse is generated.
- With start at edge 0, link_pr is high after edge 1.
- Against a single-cycle-response leaf, each payload bit takes 4 cycles: DATA for 2 cycles, NULL for 2 cycles.
- rx_msg_vld rises on the edge after the cycle in which the complete message is sampled.
- Pairs may complete on different cycles. Capture happens only in the first cycle in which all pairs are complete.
- done and busy deassertion take effect on the same edge. start may be accepted on the cycle after done.

## Configuration
- LEAF_HOST_TIMEOUT_EN defined:
  - A cycle counter clears on every state change.
  - If REQ, MSG, MACK, DATA or NULL persists for TIMEOUT_CYC cycles, set err and go to REL.
  - If REL persists for TIMEOUT_CYC cycles, pulse done and force IDLE.
- LEAF_HOST_TIMEOUT_EN undefined: no counter exists, and every wait state waits indefinitely.

## Test plan
- Leaf model drives pairs 01 on all 16 pairs, payload=8'hA5, start -> rx_msg=16'hFFFF, rx_msg_vld pulses once, link_pd token sequence 01,10,01,10,10,01,10,01, done pulse, err=0.
- Leaf drives pair 3 as 11 in MSG -> err=1, link_pr drops with no DATA state entered, done pulse, rx_msg_vld never asserts.
- start pulsed again during DATA -> ignored; exactly 8 tokens are sent and exactly one done pulse occurs.
- Pairs complete one per cycle over 16 cycles -> single capture, one cycle after the last pair completes.
- rst_n pulsed low mid-bit while link_pd=01 -> link_pr, link_pd and link_ra are 0 immediately; the FSM is in IDLE after release.
- With LEAF_HOST_TIMEOUT_EN and TIMEOUT_CYC=16, link_pa held at 0 after start -> err set after 16 cycles in REQ, REL entered, done pulse.
